// File: rtl/int_to_fp16.sv
// rtl/int_to_fp16.sv - 3-stage elastic 16-bit integer to IEEE-754 half-precision converter
//
// Purpose: produces FP16 operands from integer samples. Rounds to nearest, ties to even.
//   S1 registers sign and magnitude, S2 normalises (leading-one detect + left shift),
//   S3 rounds and packs into the output register.
//
// Parameters:
//   SIGNED_IN    1 = in_data is two's complement, 0 = in_data is unsigned
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     in_data is valid
//   in_ready     converter accepts in_data this cycle
//   in_data      integer operand [15:0]
//   out_valid    out_data is valid
//   out_ready    downstream accepts out_data
//   out_data     FP16 result {sign, exp[4:0], man[9:0]}
//   out_inexact  rounding discarded nonzero bits, or the result saturated to infinity

module int_to_fp16 #(
  parameter int SIGNED_IN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_inexact
);

  // Stage registers
  logic        s1_valid_q, s1_sign_q;
  logic [15:0] s1_mag_q;
  logic        s2_valid_q, s2_sign_q, s2_zero_q;
  logic [3:0]  s2_p_q;
  logic [15:0] s2_shf_q;
  logic        out_valid_q, out_inexact_q;
  logic [15:0] out_data_q;

  // Next-state values
  logic        s1_sign_d;
  logic [15:0] s1_mag_d;
  logic        s2_zero_d;
  logic [3:0]  s2_p_d;
  logic [15:0] s2_shf_d;
  logic [15:0] out_data_d;
  logic        out_inexact_d;

  logic        adv;

  // The whole pipe moves together; a stall freezes every stage, bubbles included.
  assign adv      = out_ready | ~out_valid_q;
  assign in_ready = adv;

  // S1: sign/magnitude. -32768 negates to 0x8000, which still fits in 16 unsigned bits.
  always_comb begin
    s1_sign_d = (SIGNED_IN != 0) ? in_data[15] : 1'b0;
    s1_mag_d  = s1_sign_d ? (~in_data + 16'd1) : in_data;
  end

  // S2: leading-one position (highest set bit wins) and normalising shift.
  always_comb begin
    s2_p_d = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (s1_mag_q[i]) s2_p_d = 4'(i);
    end
    s2_zero_d = (s1_mag_q == 16'd0);
    s2_shf_d  = s1_mag_q << (4'd15 - s2_p_d);
  end

  // S3: round to nearest even and pack.
  logic [9:0]  man;
  logic        guard, sticky, rnd_up;
  logic [10:0] man_r;
  logic [4:0]  exp_w;

  always_comb begin
    man    = s2_shf_q[14:5];
    guard  = s2_shf_q[4];
    sticky = |s2_shf_q[3:0];
    rnd_up = guard & (sticky | man[0]);
    man_r  = {1'b0, man} + {10'd0, rnd_up};
    // A mantissa carry leaves man_r[9:0] = 0 and bumps the exponent by one.
    exp_w  = {1'b0, s2_p_q} + 5'd15 + {4'd0, man_r[10]};

    out_data_d    = {s2_sign_q, exp_w, man_r[9:0]};
    out_inexact_d = guard | sticky;
    if (s2_zero_q) begin
      out_data_d    = 16'h0000;
      out_inexact_d = 1'b0;
    end else if (exp_w == 5'd31) begin
      // Only reachable for unsigned inputs >= 65520: saturate to infinity.
      out_data_d    = {s2_sign_q, 5'h1f, 10'h000};
      out_inexact_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 16'h0000;
      out_inexact_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q    <= in_valid;
      s1_sign_q     <= s1_sign_d;
      s1_mag_q      <= s1_mag_d;
      s2_valid_q    <= s1_valid_q;
      s2_sign_q     <= s1_sign_q;
      s2_zero_q     <= s2_zero_d;
      s2_p_q        <= s2_p_d;
      s2_shf_q      <= s2_shf_d;
      out_valid_q   <= s2_valid_q;
      out_data_q    <= out_data_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_int_to_fp16.sv
// tb/tb_int_to_fp16.sv - scoreboard bench for int_to_fp16, signed and unsigned instances

module tb_int_to_fp16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid[2], in_ready[2], out_valid[2], out_ready[2], out_inexact[2];
  logic [15:0] in_data[2], out_data[2];

  int_to_fp16 #(.SIGNED_IN(1)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_inexact(out_inexact[0])
  );

  int_to_fp16 #(.SIGNED_IN(0)) dut_u (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_inexact(out_inexact[1])
  );

  typedef struct {
    logic [15:0] data;
    logic        inexact;
    int          stamp;
  } exp_t;

  exp_t        sb[2][$];
  logic [16:0] dir_q[2][$];
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          holding[2];
  logic [15:0] hold_data[2];
  logic        hold_inx[2];
  exp_t        e;
  logic [16:0] r;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: value-level round-to-nearest-even via quotient/remainder. Returns {inexact, fp16}.
  function automatic logic [16:0] ref_fp(input logic [15:0] x, input bit signed_in);
    int v, a, ex, m, sh, rem, half;
    bit s, inex;
    v = signed_in ? int'($signed(x)) : int'(x);
    if (v == 0) return 17'h0;
    s  = (v < 0);
    a  = s ? -v : v;
    ex = 0;
    while (a >= (2 << ex)) ex++;
    inex = 1'b0;
    if (ex <= 10) begin
      m = a << (10 - ex);
    end else begin
      sh   = ex - 10;
      m    = a >> sh;
      rem  = a - (m << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (m % 2) == 1)) m++;
      inex = (rem != 0);
      if (m == 2048) begin
        m  = 1024;
        ex = ex + 1;
      end
    end
    if (ex + 15 >= 31) return {1'b1, s, 5'h1f, 10'h000};
    return {inex, s, 5'(ex + 15), 10'(m - 1024)};
  endfunction

  task automatic check(input string name, input int unit, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s unit%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, unit, act, expv, cyc);
    end
  endtask

  // Monitor: records accepts into the scoreboard, pops and compares on every output transfer.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        sb[u].delete();
        holding[u] = 1'b0;
      end else begin
        if (out_valid[u]) begin
          if (!out_ready[u]) begin
            check("stall_in_ready", u, int'(in_ready[u]), 0);
            if (holding[u]) begin
              check("stall_data", u, int'(out_data[u]), int'(hold_data[u]));
              check("stall_inexact", u, int'(out_inexact[u]), int'(hold_inx[u]));
            end
            holding[u]   = 1'b1;
            hold_data[u] = out_data[u];
            hold_inx[u]  = out_inexact[u];
          end else begin
            holding[u] = 1'b0;
            if (sb[u].size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL spurious_output unit%0d: got 0x%0h, expected no word (cycle %0d)", u, out_data[u], cyc);
            end else begin
              e = sb[u].pop_front();
              check("data", u, int'(out_data[u]), int'(e.data));
              check("inexact", u, int'(out_inexact[u]), int'(e.inexact));
              if (lat_chk) check("latency", u, cyc - e.stamp, 3);
            end
          end
        end
        if (in_valid[u] && in_ready[u]) begin
          if (dir_q[u].size() > 0) r = dir_q[u].pop_front();
          else r = ref_fp(in_data[u], (u == 0));
          sb[u].push_back('{data: r[15:0], inexact: r[16], stamp: cyc});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one word, waits (bounded) for the accepting edge, then drops in_valid.
  task automatic send(input int u, input logic [15:0] d, input bit use_gold, input logic [16:0] gold);
    int t;
    t = 0;
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    if (use_gold) dir_q[u].push_back(gold);
    forever begin
      @(negedge clk);
      if (in_ready[u]) break;
      t++;
      if (t > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout unit%0d: got no accept, expected one within 50 cycles", u);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] b[10];
    b = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFF0, 16'hFFEF,
          16'hFFE0, 16'h0800, 16'h0801, 16'h0FFF, 16'h8001};
    case ($urandom % 4)
      0: return 16'($urandom_range(0, 64));
      1: return b[$urandom % 10];
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u]  = 1'b0;
      in_data[u]   = 16'h0;
      out_ready[u] = 1'b1;
    end
    repeat (2) step();
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      check("reset_out_valid", u, int'(out_valid[u]), 0);
      check("reset_out_data", u, int'(out_data[u]), 0);
      check("reset_out_inexact", u, int'(out_inexact[u]), 0);
      check("reset_in_ready", u, int'(in_ready[u]), 1);
    end

    // Exact values and rounding (signed), saturation (unsigned), back to back.
    lat_chk = 1'b1;
    send(0, 16'h0000, 1, {1'b0, 16'h0000});
    send(0, 16'h0001, 1, {1'b0, 16'h3C00});
    send(0, 16'hFFFF, 1, {1'b0, 16'hBC00});
    send(0, 16'h8000, 1, {1'b0, 16'hF800});
    send(0, 16'd2049, 1, {1'b1, 16'h6800});
    send(0, 16'd2051, 1, {1'b1, 16'h6802});
    send(0, 16'd32767, 1, {1'b1, 16'h7800});
    send(1, 16'hFFFF, 1, {1'b1, 16'h7C00});
    send(1, 16'hFFE0, 1, {1'b0, 16'h7BFF});
    send(1, 16'h8000, 1, {1'b0, 16'h7800});
    repeat (6) step();
    lat_chk = 1'b0;

    // Backpressure: 8 words with a 5-cycle stall mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send(0, rand_word(), 0, 17'h0);
      end
      begin
        repeat (4) step();
        out_ready[0] = 1'b0;
        repeat (5) step();
        out_ready[0] = 1'b1;
      end
    join
    repeat (6) step();

    // Reset with 3 words in flight; a fresh word must then emerge with normal latency.
    for (int i = 0; i < 3; i++) send(0, 16'h1234 + 16'(i), 0, 17'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset_out_valid", 0, int'(out_valid[0]), 0);
    check("midreset_in_ready", 0, int'(in_ready[0]), 1);
    lat_chk = 1'b1;
    send(0, 16'd100, 1, {1'b0, 16'h5640});
    repeat (6) step();
    lat_chk = 1'b0;

    // Random traffic on both instances.
    for (int i = 0; i < 12000; i++) begin
      for (int u = 0; u < 2; u++) begin
        in_valid[u]  = ($urandom % 10) < 7;
        in_data[u]   = rand_word();
        out_ready[u] = ($urandom % 10) < 7;
      end
      step();
    end
    for (int u = 0; u < 2; u++) begin
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b1;
    end
    repeat (10) step();
    for (int u = 0; u < 2; u++) check("drain_pending", u, sb[u].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
